pad_src_ingress: RTL and testbench
==================================

Name: pad_src_ingress

Overview:
- Ingress stage directly upstream of pak_dsp.
- Takes the raw 14-bit sample bus and its valid strobe from the GPIO pads. These arrive asynchronous to wb_clk_i.
- Synchronises them and captures one sample per rising edge of the strobe.
- Buffers captured samples in a small FIFO and presents them to the filter's src_data_in / src_valid_in / src_ready_out stream port.
- Reports fill level and a sticky overflow flag for logic-analyser observation.

Parameters:
- DATA_WIDTH, 14, sample width; matches pak_dsp DATA_WIDTH.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- SYNC_STAGES, 2, flip-flop stages in the pad synchroniser; minimum 2.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- pad_data_i  in  DATA_WIDTH  raw sample from io_in[13:0]; asynchronous.
- pad_valid_i  in  1  raw strobe from io_in[14]; asynchronous level. Each rising edge carries one sample.
- pad_ready_o  out  1  flow-control hint to the external source, driven to io_out[15].
- m_data_o  out  DATA_WIDTH  sample to pak_dsp src_data_in.
- m_valid_o  out  1  to pak_dsp src_valid_in.
- m_ready_i  in  1  from pak_dsp src_ready_out.
- clear_i  in  1  synchronous flush; single-cycle pulse or level.
- level_o  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky: a captured sample was dropped because the FIFO was full.

Behaviour:
- Reset: the one clock is wb_clk_i; reset is wb_rst_i, synchronous and active-high, sampled on the rising edge of wb_clk_i.
- Reset values: all synchroniser flops 0, edge-detect history flop 0, read/write pointers 0, level_o 0, m_valid_o 0, m_data_o 0, overflow_o 0, pad_ready_o 0 in the reset cycle, then 1 in the first cycle after reset release.
- Synchroniser: pad_data_i and pad_valid_i pass through SYNC_STAGES flops. A further flop holds the previous synchronised valid.
- Capture strobe: cap = valid_sync & ~valid_prev. One pulse per rising edge of the pad strobe; a held-high strobe yields exactly one capture.
- External sources must hold pad_data_i stable from at least one clock before the strobe rises until the strobe falls.
- Capture latency, SYNC_STAGES=2: pad_valid_i first sampled high at edge E0 → cap high in the cycle after E0+1 → FIFO write at E0+2 → m_valid_o high after E0+2. With an empty FIFO, m_data_o equals the data synchronised at E0+1.
- FIFO is first-word-fall-through:
  - m_valid_o = (level != 0); m_data_o = entry at the read pointer.
  - A pop occurs on m_valid_o & m_ready_i.
  - m_data_o must hold stable while m_valid_o=1 and m_ready_i=0.
- Write rules:
  - cap with level < DEPTH: write and advance the write pointer.
  - cap with level == DEPTH: drop the sample and set overflow_o. This holds even if a pop occurs in the same cycle; there is no write-through when full.
- Level update: write only → +1; pop only → −1; write and pop together → unchanged; neither → unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Empty: no pop is possible. A simultaneous cap writes and m_valid_o rises the next cycle; there is no same-cycle bypass.
- pad_ready_o is registered; its next value is (level_next <= DEPTH−SYNC_STAGES−1). This gives margin for samples already in flight in the synchroniser.
- overflow_o clears only on reset or clear_i.
- clear_i, next edge:
  - Pointers → 0, level → 0, overflow_o → 0, m_valid_o → 0.
  - Synchroniser and history flops are not cleared.
  - A cap in the same cycle as clear_i is discarded and does not set overflow.
  - clear_i has priority over write and pop.
- Reset mid-stream: all buffered samples are lost and no spurious capture follows. A strobe still high at reset release is not captured, because the history flop must first see 0.
- No arithmetic beyond pointer and level increment; all widths are unsigned.

Decomposition:
- Shared package pak_dsp_pkg holds:
  - DSP_DATA_WIDTH = 14.
  - INGRESS_DEPTH = 8.
  - Function clog2, for pointer and level widths.
- Sub-module sync_fifo: single-clock FWFT FIFO with DATA_WIDTH and DEPTH parameters, push/pop/clear, level, full/empty.
- The synchroniser, edge detector, overflow and ready logic live in pad_src_ingress itself.

Test Plan:
- Single capture: after reset, pad_data_i=14'h1A5, pad_valid_i rises at edge E0 and is held for 5 cycles, m_ready_i=0 → m_valid_o=1 after E0+2, m_data_o=14'h1A5, level_o=1, only one entry written.
- Burst to full: 10 strobes with data 1..10, each 4 cycles high and 4 low, m_ready_i=0 → level_o reaches 8; entries 9 and 10 dropped; overflow_o=1. pad_ready_o falls when level reaches 6.
- Drain order: continue from full with m_ready_i=1 → m_data_o sequence 1..8 on consecutive cycles, then m_valid_o=0. level_o=0 and overflow_o still 1.
- Simultaneous push/pop: level=3, a cap cycle coinciding with m_ready_i=1 → level stays 3. Subsequent output order is preserved across pointer wrap after 20 mixed operations, checked against a scoreboard.
- Clear: level=5, overflow_o=1, clear_i pulsed in the same cycle as a cap → next cycle level_o=0, m_valid_o=0, overflow_o=0. The coincident sample is never output.
- Reset with strobe high: assert wb_rst_i for 2 cycles while pad_valid_i=1, then release with the strobe still high → no write occurs. The next genuine rising edge is captured normally.

Source files
------------

// File: rtl/pak_dsp_pkg.sv
// Shared constants and width helper for the pak_dsp sample path.
// Used by the pad ingress stage and its FIFO.
package pak_dsp_pkg;

  localparam int DSP_DATA_WIDTH = 14;
  localparam int INGRESS_DEPTH  = 8;

  // Ceiling log2; clog2(1) is 0, so pointer widths collapse correctly.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pad_src_ingress_if.sv
// Sample stream bundle between the ingress FIFO and the filter source port.
// valid/ready: a beat transfers on a clock edge where valid and ready are both 1; data is stable while valid=1 and ready=0.
interface pad_src_ingress_if #(
  parameter int DATA_WIDTH = pak_dsp_pkg::DSP_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on out.data.
// A push into a full FIFO is ignored even if the head pops in the same cycle.
module sync_fifo import pak_dsp_pkg::*; #(
  parameter int DATA_WIDTH = DSP_DATA_WIDTH,
  parameter int DEPTH      = INGRESS_DEPTH,
  localparam int PW        = clog2(DEPTH),
  localparam int LW        = clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  pad_src_ingress_if.master     out,
  output logic [LW-1:0]         level_o,
  output logic [LW-1:0]         level_next_o,
  output logic                  full_o
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         rd_ptr_d;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o    = (level_q == FULL_LEVEL);
  assign out.valid = (level_q != '0);
  assign out.data  = mem_q[rd_ptr_q];

  // Flush wins over both sides of the handshake.
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = out.valid & out.ready & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;

endmodule

// File: rtl/pad_src_ingress.sv
// Pad sample ingress: synchronises the raw pad bus, captures one sample per strobe rising edge,
// and buffers samples for the pak_dsp source stream with level, overflow and ready reporting.
module pad_src_ingress import pak_dsp_pkg::*; #(
  parameter int DATA_WIDTH  = DSP_DATA_WIDTH,
  parameter int DEPTH       = INGRESS_DEPTH,
  parameter int SYNC_STAGES = 2,
  localparam int LW         = clog2(DEPTH) + 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [DATA_WIDTH-1:0] pad_data_i,
  input  logic                  pad_valid_i,
  output logic                  pad_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  input  logic                  clear_i,
  output logic [LW-1:0]         level_o,
  output logic                  overflow_o
);

  // Ready threshold leaves room for samples still travelling through the synchroniser.
  localparam int READY_MAX_LEVEL = DEPTH - SYNC_STAGES - 1;

  logic [DATA_WIDTH-1:0]  data_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] valid_sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   valid_prev_q;
  logic                   armed_q;
  logic                   overflow_q;
  logic                   pad_ready_q;
  logic                   valid_s;
  logic                   cap;
  logic                   fifo_full;
  logic [LW-1:0]          fifo_level;
  logic [LW-1:0]          fifo_level_next;

  pad_src_ingress_if #(.DATA_WIDTH(DATA_WIDTH)) m_if ();

  assign valid_s = valid_sync_q[SYNC_STAGES-1];

  // armed_q stays low until the synchroniser has flushed its reset zeros and then shows a genuine
  // low strobe, so a strobe already high at reset release is never taken as an edge.
  assign cap = valid_s & ~valid_prev_q & armed_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= '0;
      end
      valid_sync_q <= '0;
      primed_q     <= '0;
      valid_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      data_sync_q[0] <= pad_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= data_sync_q[i-1];
      end
      valid_sync_q <= {valid_sync_q[SYNC_STAGES-2:0], pad_valid_i};
      primed_q     <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      valid_prev_q <= valid_s;
      armed_q      <= armed_q | (primed_q[SYNC_STAGES-1] & ~valid_s);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overflow_q  <= 1'b0;
      pad_ready_q <= 1'b0;
    end else begin
      if (clear_i) begin
        overflow_q <= 1'b0;
      end else if (cap && fifo_full) begin
        overflow_q <= 1'b1;
      end
      pad_ready_q <= (int'(fifo_level_next) <= READY_MAX_LEVEL);
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .clear_i      (clear_i),
    .push_i       (cap),
    .push_data_i  (data_sync_q[SYNC_STAGES-1]),
    .out          (m_if.master),
    .level_o      (fifo_level),
    .level_next_o (fifo_level_next),
    .full_o       (fifo_full)
  );

  assign m_if.ready  = m_ready_i;
  assign m_data_o    = m_if.data;
  assign m_valid_o   = m_if.valid;
  assign level_o     = fifo_level;
  assign overflow_o  = overflow_q;
  assign pad_ready_o = pad_ready_q;

endmodule

// File: tb/tb_pad_src_ingress.sv
// Directed bench for pad_src_ingress: capture latency, fill/overflow, drain order,
// simultaneous push/pop across pointer wrap, flush and reset with the strobe held high.
module tb_pad_src_ingress;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] pad_data;
  logic        pad_valid;
  logic        clear;
  logic        pad_ready;
  logic [3:0]  level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];
  int ops [20] = '{0, 2, 0, 2, 1, 0, 2, 0, 1, 2, 0, 2, 1, 1, 0, 2, 2, 0, 1, 2};

  pad_src_ingress_if #(.DATA_WIDTH(14)) sif ();

  always #5 clk = ~clk;

  pad_src_ingress dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .pad_data_i  (pad_data),
    .pad_valid_i (pad_valid),
    .pad_ready_o (pad_ready),
    .m_data_o    (sif.data),
    .m_valid_o   (sif.valid),
    .m_ready_i   (sif.ready),
    .clear_i     (clear),
    .level_o     (level),
    .overflow_o  (overflow)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [13:0] d, input int hi, input int lo);
    pad_data = d;
    step(1);
    pad_valid = 1'b1;
    step(hi);
    pad_valid = 1'b0;
    step(lo);
  endtask

  task automatic test_reset();
    rst = 1'b1; pad_valid = 1'b0; clear = 1'b0; pad_data = '0; sif.ready = 1'b0;
    step(2);
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sif.valid); end
    total++; if (sif.data !== 14'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", sif.data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (pad_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", pad_ready); end
    rst = 1'b0;
    step(1);
    total++; if (pad_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b exp=1", pad_ready); end
    step(4);
  endtask

  task automatic test_single_capture();
    pad_data = 14'h1A5;
    step(1);
    pad_valid = 1'b1;
    step(1);
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL single_e0_valid got=%b exp=0", sif.valid); end
    step(1);
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL single_e1_valid got=%b exp=0", sif.valid); end
    step(1);
    total++; if (sif.valid !== 1'b1) begin bad++; $display("FAIL single_e2_valid got=%b exp=1", sif.valid); end
    total++; if (sif.data !== 14'h1A5) begin bad++; $display("FAIL single_data got=%h exp=1a5", sif.data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    step(2);
    pad_valid = 1'b0;
    step(4);
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_held_level got=%0d exp=1", level); end
    sif.ready = 1'b1;
    step(1);
    sif.ready = 1'b0;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_burst_full();
    int lvl;
    for (int i = 1; i <= 10; i++) begin
      strobe(14'(i), 4, 3);
      lvl = (i < 8) ? i : 8;
      total++; if (level !== 4'(lvl)) begin bad++; $display("FAIL burst_level[%0d] got=%0d exp=%0d", i, level, lvl); end
      total++; if (pad_ready !== (lvl <= 5)) begin bad++; $display("FAIL burst_ready[%0d] got=%b exp=%b", i, pad_ready, (lvl <= 5)); end
      total++; if (overflow !== (i > 8)) begin bad++; $display("FAIL burst_overflow[%0d] got=%b exp=%b", i, overflow, (i > 8)); end
    end
  endtask

  task automatic test_drain();
    sif.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (sif.valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, sif.valid); end
      total++; if (sif.data !== 14'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, sif.data, 14'(i)); end
      step(1);
    end
    sif.ready = 1'b0;
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b exp=0", sif.valid); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_overflow got=%b exp=1", overflow); end
    total++; if (pad_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", pad_ready); end
  endtask

  task automatic pop_check(input string name);
    total++; if (sif.valid !== 1'b1 || sif.data !== exp_q[0]) begin bad++; $display("FAIL %s got=%b/%h exp=1/%h", name, sif.valid, sif.data, exp_q[0]); end
    sif.ready = 1'b1;
    step(1);
    sif.ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [13:0] d;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_clear_overflow got=%b exp=0", overflow); end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      strobe(14'h100 + 14'(i), 2, 2);
      exp_q.push_back(14'h100 + 14'(i));
    end
    total++; if (level !== 4'd3) begin bad++; $display("FAIL b2b_level3 got=%0d exp=3", level); end
    pad_data = 14'h103;
    step(1);
    pad_valid = 1'b1;
    step(2);
    pop_check("b2b_coincident_head");
    exp_q.push_back(14'h103);
    total++; if (level !== 4'd3) begin bad++; $display("FAIL b2b_coincident_level got=%0d exp=3", level); end
    step(2);
    pad_valid = 1'b0;
    step(3);
    for (int k = 0; k < 20; k++) begin
      d = 14'h200 + 14'(k);
      if (ops[k] == 1) begin
        pop_check("b2b_pop");
      end else begin
        pad_data = d;
        step(1);
        pad_valid = 1'b1;
        step(2);
        if (ops[k] == 2) pop_check("b2b_pushpop");
        else step(1);
        exp_q.push_back(d);
        step(1);
        pad_valid = 1'b0;
        step(3);
      end
      total++; if (level !== 4'(exp_q.size())) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=%0d", k, level, exp_q.size()); end
    end
    for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
      pop_check("b2b_drain");
    end
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL b2b_final_valid got=%b exp=0", sif.valid); end
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 9; i++) strobe(14'h300 + 14'(i), 2, 2);
    total++; if (level !== 4'd8) begin bad++; $display("FAIL clear_fill_level got=%0d exp=8", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clear_fill_overflow got=%b exp=1", overflow); end
    sif.ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      total++; if (sif.data !== 14'h300 + 14'(i)) begin bad++; $display("FAIL clear_pre_pop[%0d] got=%h exp=%h", i, sif.data, 14'h300 + 14'(i)); end
      step(1);
    end
    sif.ready = 1'b0;
    total++; if (level !== 4'd5) begin bad++; $display("FAIL clear_level5 got=%0d exp=5", level); end
    pad_data = 14'h3FF;
    step(1);
    pad_valid = 1'b1;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL clear_level got=%0d exp=0", level); end
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b exp=0", sif.valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
    step(2);
    pad_valid = 1'b0;
    step(3);
    total++; if (level !== 4'd0 || sif.valid !== 1'b0) begin bad++; $display("FAIL clear_discard got=%0d/%b exp=0/0", level, sif.valid); end
    strobe(14'h055, 2, 2);
    total++; if (sif.data !== 14'h055 || level !== 4'd1) begin bad++; $display("FAIL clear_next got=%h/%0d exp=055/1", sif.data, level); end
    sif.ready = 1'b1;
    step(1);
    sif.ready = 1'b0;
  endtask

  task automatic test_reset_strobe();
    strobe(14'h111, 2, 2);
    total++; if (level !== 4'd1) begin bad++; $display("FAIL rststb_pre_level got=%0d exp=1", level); end
    pad_data = 14'h2AA;
    pad_valid = 1'b1;
    rst = 1'b1;
    step(2);
    total++; if (level !== 4'd0 || sif.valid !== 1'b0) begin bad++; $display("FAIL rststb_in_reset got=%0d/%b exp=0/0", level, sif.valid); end
    rst = 1'b0;
    step(6);
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rststb_no_capture got=%0d exp=0", level); end
    total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL rststb_valid got=%b exp=0", sif.valid); end
    pad_valid = 1'b0;
    step(4);
    strobe(14'h2AB, 2, 2);
    total++; if (level !== 4'd1) begin bad++; $display("FAIL rststb_next_level got=%0d exp=1", level); end
    total++; if (sif.data !== 14'h2AB || sif.valid !== 1'b1) begin bad++; $display("FAIL rststb_next_data got=%h/%b exp=2ab/1", sif.data, sif.valid); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_burst_full();
    test_drain();
    test_back_to_back();
    test_clear();
    test_reset_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
